// File: rtl/axi_lite_read_responder.sv
// AXI4-Lite read responder: one outstanding AR, decodes range/alignment/protection,
// fetches the word from a synchronous register file and holds the R beat until accepted.
module axi_lite_read_responder #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned SECURE_ONLY = 0,
   localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              ARVALID,
   output logic              ARREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic [2:0]        ARPROT,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [31:0]       RDATA,
   output logic [1:0]        RRESP,
   output logic              mem_rd_en,
   output logic [IDX_W-1:0]  mem_rd_addr,
   input  logic [31:0]       mem_rd_data
);

   localparam int unsigned     CNT_W      = 2;
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS * 4);
   localparam logic [1:0]      RESP_OKAY  = 2'b00;
   localparam logic [1:0]      RESP_SLV   = 2'b10;
   localparam logic [1:0]      RESP_DEC   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_n;
   logic               arready_n;
   logic               rvalid_n;
   logic [31:0]        rdata_n;
   logic [1:0]         rresp_n;
   logic               rd_en_n;
   logic [IDX_W-1:0]   rd_addr_n;

   logic               addr_oor;
   logic               addr_mis;
   logic               prot_bad;
   logic               unused_prot;

   // Address decode, evaluated only in the handshake cycle
   assign addr_oor    = ({1'b0, ARADDR} >= ADDR_LIMIT);
   assign addr_mis    = (ARADDR[1:0] != 2'b00);
   assign prot_bad    = (SECURE_ONLY != 0) && ARPROT[1];
   assign unused_prot = ^ARPROT;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state       <= S_IDLE;
         cnt         <= '0;
         ARREADY     <= 1'b0;
         RVALID      <= 1'b0;
         RDATA       <= '0;
         RRESP       <= RESP_OKAY;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         ARREADY     <= arready_n;
         RVALID      <= rvalid_n;
         RDATA       <= rdata_n;
         RRESP       <= rresp_n;
         mem_rd_en   <= rd_en_n;
         mem_rd_addr <= rd_addr_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      arready_n = ARREADY;
      rvalid_n  = RVALID;
      rdata_n   = RDATA;
      rresp_n   = RRESP;
      rd_en_n   = 1'b0;
      rd_addr_n = mem_rd_addr;

      case (state)
         S_IDLE: begin
            arready_n = 1'b1;
            if (ARVALID && ARREADY) begin
               arready_n = 1'b0;
               rd_addr_n = ARADDR[IDX_W+1:2];
               if (addr_oor) begin
                  state_n  = S_RESP;
                  rvalid_n = 1'b1;
                  rdata_n  = '0;
                  rresp_n  = RESP_DEC;
               end else if (addr_mis || prot_bad) begin
                  state_n  = S_RESP;
                  rvalid_n = 1'b1;
                  rdata_n  = '0;
                  rresp_n  = RESP_SLV;
               end else begin
                  // Strobe is high for exactly the READ cycle
                  state_n = S_READ;
                  rd_en_n = 1'b1;
               end
            end
         end

         S_READ: begin
            cnt_n   = CNT_W'(RD_LATENCY - 1);
            state_n = S_WAIT;
         end

         S_WAIT: begin
            if (cnt == '0) begin
               rdata_n  = mem_rd_data;
               rresp_n  = RESP_OKAY;
               rvalid_n = 1'b1;
               state_n  = S_RESP;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end

         S_RESP: begin
            if (RVALID && RREADY) begin
               rvalid_n  = 1'b0;
               arready_n = 1'b1;
               state_n   = S_IDLE;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule
